// File: rtl/serial_pkg.sv
// Shared types and helpers for the multi-lane serial transceiver.
package serial_pkg;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  function automatic int frame_len(input int data_w, input int parity_en);
    return data_w + 2 + parity_en;
  endfunction

  // Callers zero-extend; extra zero bits do not change the XOR.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_rx_lane.sv
// One receive lane: 2-flop synchroniser, framing FSM, bit-centre sampling.
module serial_rx_lane
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_parity_err,
  output logic              o_frame_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic              r_s1, r_s2;
  rx_state_e         r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              w_rx, w_tick;

  assign w_rx   = r_s2;
  assign w_tick = (r_cnt == FULL_M1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:   if (!w_rx) w_next = RX_START;
      // Half-bit recheck rejects short glitches and centres later samples.
      RX_START:  if (r_cnt == HALF_M1) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_tick && r_bit == LAST_BIT)
                   w_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_tick) w_next = RX_STOP;
      RX_STOP:   if (w_tick) w_next = w_rx ? RX_IDLE : RX_BREAK;
      RX_BREAK:  if (w_rx) w_next = RX_IDLE;
      default:   w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1         <= 1'b1;
      r_s2         <= 1'b1;
      r_state      <= RX_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_s1    <= i_rx;
      r_s2    <= r_s1;
      r_state <= w_next;
      o_valid <= 1'b0;
      if (w_next != r_state || w_tick || r_state == RX_IDLE) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_START) r_bit <= '0;
      if (r_state == RX_DATA && w_tick) begin
        r_shift <= {w_rx, r_shift[DATA_W-1:1]};
        r_bit   <= r_bit + 1'b1;
      end
      if (r_state == RX_PARITY && w_tick) r_par <= w_rx;
      if (r_state == RX_STOP && w_tick) begin
        o_data       <= r_shift;
        o_valid      <= 1'b1;
        o_parity_err <= (PARITY_EN != 0) && (r_par != even_parity(64'(r_shift)));
        o_frame_err  <= !w_rx;
      end
    end
  end
endmodule

// File: rtl/serial_link_xcvr.sv
// Multi-lane framed serial transceiver: lockstep TX with valid/ready, per-lane RX.
module serial_link_xcvr
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int CLK_DIV   = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [LANES-1:0]        serial_tx,
  input  logic [LANES-1:0]        serial_rx,
  output logic [LANES*DATA_W-1:0] rx_data,
  output logic [LANES-1:0]        rx_valid,
  output logic [LANES-1:0]        rx_parity_err,
  output logic [LANES-1:0]        rx_frame_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] FULL_M1  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_e                    r_state, w_next;
  logic [CW-1:0]                r_cnt;
  logic [BW-1:0]                r_bit, w_bit_next;
  logic [LANES-1:0][DATA_W-1:0] r_data;
  logic                         r_ready;
  logic [LANES-1:0]             r_tx, w_line;
  logic                         w_accept, w_tick;
  logic [LANES-1:0][DATA_W-1:0] w_rx_data;

  assign w_accept  = tx_valid && r_ready;
  assign w_tick    = (r_cnt == FULL_M1);
  assign tx_ready  = r_ready;
  assign serial_tx = r_tx;
  assign rx_data   = w_rx_data;

  always_comb begin
    w_next     = r_state;
    w_bit_next = r_bit;
    case (r_state)
      TX_IDLE: begin
        w_bit_next = '0;
        if (w_accept) w_next = TX_START;
      end
      TX_START:  if (w_tick) w_next = TX_DATA;
      TX_DATA:   if (w_tick) begin
                   if (r_bit == LAST_BIT) w_next = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                   else                   w_bit_next = r_bit + 1'b1;
                 end
      TX_PARITY: if (w_tick) w_next = TX_STOP;
      TX_STOP:   if (w_tick) w_next = TX_IDLE;
      default:   w_next = TX_IDLE;
    endcase
  end

  // Line level is computed from the next state so the pin is a clean flop output.
  always_comb begin
    w_line = '1;
    for (int k = 0; k < LANES; k++) begin
      case (w_next)
        TX_START:  w_line[k] = 1'b0;
        TX_DATA:   w_line[k] = r_data[k][w_bit_next];
        TX_PARITY: w_line[k] = even_parity(64'(r_data[k]));
        default:   w_line[k] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_tx    <= '1;
    end else begin
      r_state <= w_next;
      r_bit   <= w_bit_next;
      r_ready <= (w_next == TX_IDLE);
      r_tx    <= w_line;
      if (w_accept) r_data <= tx_data;
      if (r_state == TX_IDLE || w_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_rx
    serial_rx_lane #(
      .DATA_W   (DATA_W),
      .CLK_DIV  (CLK_DIV),
      .PARITY_EN(PARITY_EN)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (serial_rx[k]),
      .o_data      (w_rx_data[k]),
      .o_valid     (rx_valid[k]),
      .o_parity_err(rx_parity_err[k]),
      .o_frame_err (rx_frame_err[k])
    );
  end
endmodule
